// File: rtl/aes_rnd_ctrl_if.sv
// Signal bundle between aes_rnd_ctrl and its front end, key store and round datapath.
// slave is the controller's view; master is the view of everything around it.
interface aes_rnd_ctrl_if #(
    parameter int unsigned RND_SIZE = 128,
    parameter int unsigned IDX_W    = 4
);
    logic                i_clr;
    logic                i_pt_valid;
    logic                o_pt_ready;
    logic [RND_SIZE-1:0] i_pt_text;
    logic [IDX_W-1:0]    o_key_idx;
    logic [RND_SIZE-1:0] i_key;
    logic [RND_SIZE-1:0] o_rnd_text;
    logic [RND_SIZE-1:0] o_rnd_key;
    logic                o_lst_rnd;
    logic [RND_SIZE-1:0] i_rnd_cypher;
    logic                o_ct_valid;
    logic                i_ct_ready;
    logic [RND_SIZE-1:0] o_ct_text;
    logic                o_busy;

    modport slave (
        input  i_clr, i_pt_valid, i_pt_text, i_key, i_rnd_cypher, i_ct_ready,
        output o_pt_ready, o_key_idx, o_rnd_text, o_rnd_key, o_lst_rnd, o_ct_valid, o_ct_text,
               o_busy
    );

    modport master (
        output i_clr, i_pt_valid, i_pt_text, i_key, i_rnd_cypher, i_ct_ready,
        input  o_pt_ready, o_key_idx, o_rnd_text, o_rnd_key, o_lst_rnd, o_ct_valid, o_ct_text,
               o_busy
    );
endinterface

// File: rtl/aes_rnd_ctrl.sv
// Sequences one shared aes_round instance through a full AES block encryption:
// key-0 whitening on accept, then NUM_RND rounds of RND_LAT+1 cycles each.
module aes_rnd_ctrl #(
    parameter int unsigned RND_SIZE = 128,
    parameter int unsigned NUM_RND  = 10,
    parameter int unsigned RND_LAT  = 1,
    parameter int unsigned IDX_W    = 4
) (
    input logic           clk,
    input logic           rst_n,
    aes_rnd_ctrl_if.slave bus
);
    localparam int unsigned LAT_W = 3;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_RND);
    localparam logic [LAT_W-1:0] LastLat = LAT_W'(RND_LAT);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [RND_SIZE-1:0] text_q, text_d;
    logic [IDX_W-1:0]    rnd_cnt_q, rnd_cnt_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            text_q    <= '0;
            rnd_cnt_q <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            text_q    <= text_d;
            rnd_cnt_q <= rnd_cnt_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        text_d    = text_q;
        rnd_cnt_d = rnd_cnt_q;
        lat_cnt_d = lat_cnt_q;
        if (bus.i_clr) begin
            state_d   = StIdle;
            text_d    = '0;
            rnd_cnt_d = '0;
            lat_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.i_pt_valid) begin
                        text_d    = bus.i_pt_text ^ bus.i_key;
                        rnd_cnt_d = IDX_W'(1);
                        lat_cnt_d = '0;
                        state_d   = StRun;
                    end
                end
                StRun: begin
                    if (lat_cnt_q == LastLat) begin
                        text_d    = bus.i_rnd_cypher;
                        lat_cnt_d = '0;
                        // Park the counter on the last index so the key index never overruns.
                        if (rnd_cnt_q == LastIdx) begin
                            state_d = StDone;
                        end else begin
                            rnd_cnt_d = rnd_cnt_q + IDX_W'(1);
                        end
                    end else begin
                        lat_cnt_d = lat_cnt_q + LAT_W'(1);
                    end
                end
                StDone: begin
                    if (bus.i_ct_ready) begin
                        state_d   = StIdle;
                        rnd_cnt_d = '0;
                    end
                end
                default: begin
                    state_d   = StIdle;
                    rnd_cnt_d = '0;
                    lat_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        // Ready is withheld during a clear so a concurrent valid never looks like a handshake.
        bus.o_pt_ready = (state_q == StIdle) && !bus.i_clr;
        bus.o_key_idx  = (state_q == StIdle) ? '0 : rnd_cnt_q;
        bus.o_lst_rnd  = (state_q == StRun) && (rnd_cnt_q == LastIdx);
        bus.o_rnd_text = text_q;
        bus.o_rnd_key  = bus.i_key;
        bus.o_ct_valid = (state_q == StDone);
        bus.o_ct_text  = text_q;
        bus.o_busy     = (state_q == StRun) || (state_q == StDone);
    end

    a_ct_hold: assert property (@(posedge clk) disable iff (!rst_n)
        bus.o_ct_valid && !bus.i_ct_ready && !bus.i_clr
        |=> bus.o_ct_valid && $stable(bus.o_ct_text));

    a_rnd_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StRun) && (lat_cnt_q != LastLat) && !bus.i_clr
        |=> $stable(bus.o_rnd_text) && $stable(bus.o_key_idx));

    a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
        bus.o_key_idx <= LastIdx);

    a_busy_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
        bus.o_busy |-> !bus.o_pt_ready);
endmodule

// File: tb/tb_aes_rnd_ctrl.sv
// Bench for aes_rnd_ctrl: a default build and an RND_LAT=0 build, each wrapped with a
// behavioural aes_round and key store; a reference AES-128 feeds a ct scoreboard.
module tb_aes_rnd_ctrl;
    localparam int NUM_RND  = 10;
    localparam int LAT0     = 1;
    localparam int LAT1     = 0;
    localparam int LAT0_TOT = NUM_RND * (LAT0 + 1) + 1;
    localparam int LAT1_TOT = NUM_RND * (LAT1 + 1) + 1;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [127:0] ct;
        int           t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   hold0 = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [NUM_RND:0][127:0] ks;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_rnd_ctrl_if #(.RND_SIZE(128), .IDX_W(4)) m0 ();
    aes_rnd_ctrl_if #(.RND_SIZE(128), .IDX_W(4)) m1 ();

    aes_rnd_ctrl #(.RND_SIZE(128), .NUM_RND(NUM_RND), .RND_LAT(LAT0), .IDX_W(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m0.slave)
    );

    aes_rnd_ctrl #(.RND_SIZE(128), .NUM_RND(NUM_RND), .RND_LAT(LAT1), .IDX_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m1.slave)
    );

    // ---------------- AES reference (FIPS-197 byte order: byte 0 is bits 127:120)
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0]  inv, p, e;
        logic [15:0] d;
        inv = 8'h01;
        p   = a;
        e   = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, p);
            p = gmul(p, p);
        end
        d = {inv, inv};
        return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    endfunction

    function automatic logic [127:0] rnd_f(input logic [127:0] s, input logic [127:0] k,
                                           input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) t[4*c+j] = b[4*((c+j)%4)+j];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r ^ k;
    endfunction

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NUM_RND; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ ks[0];
        for (int r = 1; r <= NUM_RND; r++) s = rnd_f(s, ks[r], r == NUM_RND);
        return s;
    endfunction

    // ---------------- environment: key store and round datapaths
    always_comb m0.i_key = (int'(m0.o_key_idx) <= NUM_RND) ? ks[m0.o_key_idx] : '0;
    always_comb m1.i_key = (int'(m1.o_key_idx) <= NUM_RND) ? ks[m1.o_key_idx] : '0;
    always @(posedge clk) m0.i_rnd_cypher <= rnd_f(m0.o_rnd_text, m0.o_rnd_key, m0.o_lst_rnd);
    always_comb m1.i_rnd_cypher = rnd_f(m1.o_rnd_text, m1.o_rnd_key, m1.o_lst_rnd);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- consumer for dut0: holds ready low for hold0 valid cycles
    initial begin : cons0
        int cnt;
        cnt = 0;
        m0.i_ct_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (m0.o_ct_valid) begin
                cnt++;
                m0.i_ct_ready = (cnt > hold0);
            end else begin
                cnt = 0;
                m0.i_ct_ready = 1'b0;
            end
        end
    end

    // ---------------- monitors / scoreboards
    initial begin : mon0
        bit           vp, hsp;
        logic [127:0] held;
        exp_t         e;
        vp = 0;
        hsp = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                vp = 0;
                hsp = 0;
                continue;
            end
            if (hsp) chk("pt_ready_after_ct_hs", 128'(m0.o_pt_ready), 128'(1));
            if (m0.o_ct_valid && !vp) begin
                if (q0.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_ct0: got %h, want no ciphertext", m0.o_ct_text);
                end else begin
                    e = q0.pop_front();
                    chk("ct0", m0.o_ct_text, e.ct);
                    chk("ct0_latency", 128'(cyc - e.t), 128'(LAT0_TOT));
                end
                chk("pt_ready_in_done", 128'(m0.o_pt_ready), 128'(0));
                held = m0.o_ct_text;
            end else if (m0.o_ct_valid && !hsp) begin
                chk("ct0_stable", m0.o_ct_text, held);
                chk("pt_ready_in_bp", 128'(m0.o_pt_ready), 128'(0));
            end
            hsp = m0.o_ct_valid && m0.i_ct_ready;
            vp  = m0.o_ct_valid;
        end
    end

    initial begin : mon1
        bit   vp;
        exp_t e;
        vp = 0;
        forever begin
            @(negedge clk);
            if (rst_n && m1.o_ct_valid && !vp) begin
                if (q1.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_ct1: got %h, want no ciphertext", m1.o_ct_text);
                end else begin
                    e = q1.pop_front();
                    chk("ct1", m1.o_ct_text, e.ct);
                    chk("ct1_latency", 128'(cyc - e.t), 128'(LAT1_TOT));
                end
            end
            vp = rst_n && m1.o_ct_valid;
        end
    end

    // ---------------- stimulus helpers for dut0
    task automatic send0(input logic [127:0] pt, input logic [127:0] ct, input bit push,
                         input bit trace);
        int   n, k;
        exp_t e;
        @(posedge clk);
        #1;
        m0.i_pt_valid = 1'b1;
        m0.i_pt_text  = pt;
        n = 0;
        @(negedge clk);
        while (!m0.o_pt_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pt_accept_wait", 128'(m0.o_pt_ready), 128'(1));
        if (push && m0.o_pt_ready) begin
            e.ct = ct;
            e.t  = cyc;
            q0.push_back(e);
        end
        @(posedge clk);
        #1;
        m0.i_pt_valid = 1'b0;
        if (trace) begin
            for (int i = 1; i < LAT0_TOT; i++) begin
                @(negedge clk);
                k = (i + LAT0) / (LAT0 + 1);
                chk("key_idx_trace", 128'(m0.o_key_idx), 128'(k));
                chk("lst_rnd_trace", 128'(m0.o_lst_rnd), 128'(k == NUM_RND));
                chk("busy_in_run", 128'(m0.o_busy), 128'(1));
            end
        end
    endtask

    task automatic wait_done0();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((q0.size() != 0 || m0.o_busy) && n < 400);
        chk("drain0", 128'(q0.size() != 0 || m0.o_busy), 128'(0));
    endtask

    task automatic chk_idle0(input string name);
        chk({name, "_pt_ready"}, 128'(m0.o_pt_ready), 128'(1));
        chk({name, "_ct_valid"}, 128'(m0.o_ct_valid), 128'(0));
        chk({name, "_busy"}, 128'(m0.o_busy), 128'(0));
        chk({name, "_key_idx"}, 128'(m0.o_key_idx), 128'(0));
        chk({name, "_lst_rnd"}, 128'(m0.o_lst_rnd), 128'(0));
    endtask

    // ---------------- main sequence
    initial begin : stim
        logic [127:0] pt;
        int           n;
        exp_t         e;
        rst_n = 1'b0;
        m0.i_clr = 1'b0; m0.i_pt_valid = 1'b0; m0.i_pt_text = '0;
        m1.i_clr = 1'b0; m1.i_pt_valid = 1'b0; m1.i_pt_text = '0; m1.i_ct_ready = 1'b1;
        load_key(FIPS_KEY);

        // Reset
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_idle0("in_reset");
        chk("in_reset_text", m0.o_rnd_text, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle0("after_reset");

        // FIPS-197 C.1 with key-index trace
        hold0 = 0;
        send0(FIPS_PT, FIPS_CT, 1, 1);
        wait_done0();

        // Backpressure for 8 cycles
        hold0 = 8;
        send0(FIPS_PT, FIPS_CT, 1, 0);
        wait_done0();
        hold0 = 0;

        // Clear in IDLE together with valid: block must not be taken
        @(posedge clk);
        #1;
        m0.i_pt_valid = 1'b1; m0.i_pt_text = FIPS_PT; m0.i_clr = 1'b1;
        @(posedge clk);
        #1;
        m0.i_pt_valid = 1'b0; m0.i_clr = 1'b0;
        @(negedge clk);
        chk("clr_idle_no_accept", 128'(m0.o_busy), 128'(0));

        // Abort at T+9
        send0(FIPS_PT, '0, 0, 0);
        repeat (8) @(posedge clk);
        #1;
        m0.i_clr = 1'b1;
        @(negedge clk);
        chk("clr_not_yet_effective", 128'(m0.o_busy), 128'(1));
        @(posedge clk);
        #1;
        m0.i_clr = 1'b0;
        @(negedge clk);
        chk_idle0("after_clr");
        chk("after_clr_text", m0.o_rnd_text, '0);
        repeat (30) @(posedge clk);
        send0(FIPS_PT, FIPS_CT, 1, 0);
        wait_done0();

        // Randomized blocks, keys and backpressure
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                wait_done0();
                load_key({$urandom, $urandom, $urandom, $urandom});
            end
            hold0 = $urandom_range(0, 3);
            pt = {$urandom, $urandom, $urandom, $urandom};
            send0(pt, ref_enc(pt), 1, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_done0();

        // Reset mid-block: no ciphertext may appear
        send0({$urandom, $urandom, $urandom, $urandom}, '0, 0, 0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle0("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("after_mid_reset_busy", 128'(m0.o_busy), 128'(0));

        // RND_LAT=0 build: FIPS vector, valid held high through RUN
        load_key(FIPS_KEY);
        @(posedge clk);
        #1;
        m1.i_pt_valid = 1'b1;
        m1.i_pt_text  = FIPS_PT;
        @(negedge clk);
        chk("lat0_accept", 128'(m1.o_pt_ready), 128'(1));
        e.ct = FIPS_CT;
        e.t  = cyc;
        q1.push_back(e);
        @(posedge clk);
        #1;
        m1.i_pt_text = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i <= NUM_RND; i++) begin
            @(negedge clk);
            chk("lat0_ready_in_run", 128'(m1.o_pt_ready), 128'(0));
            chk("lat0_key_idx", 128'(m1.o_key_idx), 128'(i));
        end
        @(posedge clk);
        #1;
        m1.i_pt_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((q1.size() != 0 || m1.o_busy) && n < 100);
        chk("drain1", 128'(q1.size() != 0 || m1.o_busy), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
